// File: rtl/nixie_scan_driver.sv
// Double-buffered 4-digit multiplexed display driver with dead time between digit slots.
// Optional leading-zero blanking is enabled by defining NIXIE_LZB_EN.
module nixie_scan_driver #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] frame_in,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int unsigned MaxCnt   = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int unsigned CntW     = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam bit          HasBlank = (BLANK_CYCLES != 0);
  localparam logic [CntW-1:0] ShowLast  = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] BlankLast = HasBlank ? CntW'(BLANK_CYCLES - 1) : '0;

  typedef enum logic {StBlank, StShow} state_e;
  localparam state_e StInit = HasBlank ? StBlank : StShow;

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [1:0]      digit_q, digit_d;
  logic [31:0]     active_q, active_d;
  logic [31:0]     pending_q, pending_d;
  logic            ready_q, ready_d;
  logic [7:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            done_q, done_d;
  logic            boundary;

`ifdef NIXIE_LZB_EN
  logic [3:0] lead_zero;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q + 1'b1;
    digit_d   = digit_q;
    active_d  = active_q;
    pending_d = pending_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    boundary  = 1'b0;

    unique case (state_q)
      StBlank: begin
        if (count_q == BlankLast) begin
          state_d = StShow;
          count_d = '0;
        end
      end
      StShow: begin
        if (count_q == ShowLast) begin
          state_d  = HasBlank ? StBlank : StShow;
          count_d  = '0;
          digit_d  = digit_q + 2'd1;
          boundary = (digit_q == 2'd3);
        end
      end
      default: begin
        state_d = StInit;
        count_d = '0;
      end
    endcase

    // Swap only at the frame boundary so a frame is never torn mid-scan.
    if (boundary) begin
      done_d = 1'b1;
      if (!ready_q) begin
        active_d = pending_q;
        ready_d  = 1'b1;
      end
    end

    // ready_q is low whenever pending is full, so this never collides with the swap.
    if (frame_valid && ready_q) begin
      pending_d = frame_in;
      ready_d   = 1'b0;
    end
  end

`ifdef NIXIE_LZB_EN
  always_comb begin
    lead_zero[0] = (active_d[7:0] == 8'hC0);
    lead_zero[1] = lead_zero[0] && (active_d[15:8] == 8'hC0);
    lead_zero[2] = lead_zero[1] && (active_d[23:16] == 8'hC0);
    lead_zero[3] = 1'b0;
  end
`endif

  // Outputs derive from next-state values so they switch on the same edge as the FSM.
  always_comb begin
    seg_d = 8'hFF;
    an_d  = 4'hF;
    if (state_d == StShow) begin
      an_d  = ~(4'b0001 << digit_d);
      seg_d = active_d[8*digit_d +: 8];
`ifdef NIXIE_LZB_EN
      if (lead_zero[digit_d]) seg_d = 8'hFF;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StInit;
      count_q   <= '0;
      digit_q   <= 2'd0;
      active_q  <= 32'hFFFF_FFFF;
      pending_q <= 32'hFFFF_FFFF;
      ready_q   <= 1'b1;
      seg_q     <= 8'hFF;
      an_q      <= 4'hF;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      digit_q   <= digit_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      done_q    <= done_d;
    end
  end

  assign frame_ready = ready_q;
  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_nixie_scan_driver.sv
// Scoreboard bench for nixie_scan_driver: a slot/frame arithmetic model predicts every cycle.
module tb_nixie_scan_driver;

  localparam int unsigned ScanDiv = 4;
  localparam int unsigned BlankCy = 2;
  localparam int unsigned SlotLen = ScanDiv + BlankCy;
  localparam int unsigned FrameLen = 4 * SlotLen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] frame_in = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  nixie_scan_driver #(
    .SCAN_DIV     (ScanDiv),
    .BLANK_CYCLES (BlankCy)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .seg         (seg),
    .an          (an),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic       done;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: cycles since reset, plus active/pending frames.
  int          k = 0;
  logic [31:0] m_active = 32'hFFFF_FFFF;
  logic [31:0] m_pend = '0;
  bit          m_full = 0;

  function automatic logic [7:0] model_seg(input logic [31:0] act, input int d);
    logic [7:0] b;
    b = act[8*d +: 8];
`ifdef NIXIE_LZB_EN
    if (d < 3) begin
      bit all_zero = 1;
      for (int i = 0; i <= d; i++) if (act[8*i +: 8] != 8'hC0) all_zero = 0;
      if (all_zero) b = 8'hFF;
    end
`endif
    return b;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int p, s, o;
    bit acc;
    if (!rst_n) begin
      k = 0;
      m_active = 32'hFFFF_FFFF;
      m_full = 0;
    end else begin
      acc = frame_valid && !m_full;
      k++;
      if ((k % FrameLen) == 0 && m_full) begin
        m_active = m_pend;
        m_full = 0;
      end
      if (acc) begin
        m_pend = frame_in;
        m_full = 1;
      end
    end
    p = k % FrameLen;
    s = p / SlotLen;
    o = p % SlotLen;
    e.rdy  = !m_full;
    e.done = (k > 0) && (p == 0);
    if (o < BlankCy) begin
      e.seg = 8'hFF;
      e.an  = 4'hF;
    end else begin
      e.seg = model_seg(m_active, s);
      e.an  = ~(4'b0001 << s);
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({seg, an, frame_done, frame_ready} !== e) begin
        n_err++;
        $display("FAIL outputs t=%0t got seg=%h an=%b done=%b rdy=%b want seg=%h an=%b done=%b rdy=%b",
                 $time, seg, an, frame_done, frame_ready, e.seg, e.an, e.done, e.rdy);
      end
    end
  end

  task automatic send_frame(input logic [31:0] f);
    bit got = 0;
    frame_in = f;
    frame_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = frame_ready;
      @(posedge clk);
      #1;
    end
    frame_valid = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout frame=%h got ready=0 want ready=1 within 200 cycles", f);
    end
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout got frame_done=0 want 1 within 200 cycles");
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] f;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;

    // Load before first boundary, then watch several frames.
    send_frame(32'h4433_2211);
    run(60);

    // Load mid-frame (digit 1 slot), then a second frame held while pending is full.
    wait_done();
    run(8);
    send_frame(32'h8877_6655);
    send_frame(32'hAAAA_AAAA);
    run(60);

    // Randomized frames and gaps.
    for (int n = 0; n < 12; n++) begin
      for (int b = 0; b < 4; b++) begin
        case ($urandom_range(0, 3))
          0: f[8*b +: 8] = 8'hC0;
          1: f[8*b +: 8] = 8'hFF;
          default: f[8*b +: 8] = 8'($urandom);
        endcase
      end
      run($urandom_range(0, 30));
      send_frame(f);
    end
    run(60);

    // Leading-zero patterns.
    send_frame(32'h11C0_C0C0);
    send_frame(32'hC0C0_C0C0);
    run(60);

    // Reset during digit 2 SHOW with a pending frame.
    wait_done();
    run(1);
    send_frame(32'h1234_5678);
    run(14);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({seg, an, frame_done, frame_ready} !== {8'hFF, 4'hF, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL async_reset got seg=%h an=%b done=%b rdy=%b want seg=ff an=1111 done=0 rdy=1",
               seg, an, frame_done, frame_ready);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
